// File: rtl/stopwatch_control.sv
// Stopwatch operator front end: conditions the raw KEY0/KEY1 push buttons
// (synchroniser + debouncer + press detector) and runs the
// start/pause/lap/clear state machine that drives the time chain.

module StopwatchKeyConditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 19
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Accept a new key level only after it has disagreed with the current one for a full window
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounce state and registered press pulse; idle level is released (high)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 19
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_key_start_n,
    input  logic       i_key_lap_n,
    output logic       o_run,
    output logic       o_freeze,
    output logic       o_clear,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } state_t;

    logic   start_press;
    logic   lap_press;
    state_t state_q;
    state_t state_d;
    logic   run_q;
    logic   run_d;
    logic   freeze_q;
    logic   freeze_d;
    logic   clear_q;
    logic   clear_d;

    StopwatchKeyConditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_start_key (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_key_n (i_key_start_n),
        .o_press (start_press)
    );

    StopwatchKeyConditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_lap_key (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_key_n (i_key_lap_n),
        .o_press (lap_press)
    );

    // Next state and next outputs; start takes priority so a simultaneous lap is dropped
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_press) begin
                    state_d = RUNNING;
                end else if (lap_press) begin
                    clear_d = 1'b1;
                end
            end
            RUNNING: begin
                if (start_press) begin
                    state_d = PAUSED;
                end else if (lap_press) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (start_press) begin
                    state_d = PAUSED;
                end else if (lap_press) begin
                    state_d = RUNNING;
                end
            end
            PAUSED: begin
                if (start_press) begin
                    state_d = RUNNING;
                end else if (lap_press) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        run_d    = (state_d == RUNNING) || (state_d == LAP);
        freeze_d = (state_d == LAP);
    end

    // State and output registers so the time chain sees glitch-free controls
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            freeze_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            freeze_q <= freeze_d;
            clear_q  <= clear_d;
        end
    end

    assign o_run    = run_q;
    assign o_freeze = freeze_q;
    assign o_clear  = clear_q;
    assign o_state  = state_q;

endmodule
